// File: rtl/pixel_reset_seq_if.sv
// Lock status in, staged pixel-domain resets and loss statistics out.
interface pixel_reset_seq_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 8
);
    logic                  locked;
    logic                  clr_count;
    logic [NUM_STAGES-1:0] rst_stage;
    logic                  ready;
    logic                  loss_pulse;
    logic [CNT_W-1:0]      loss_count;
    logic [2:0]            state;

    modport master (
        output locked, clr_count,
        input  rst_stage, ready, loss_pulse, loss_count, state
    );

    modport slave (
        input  locked, clr_count,
        output rst_stage, ready, loss_pulse, loss_count, state
    );
endinterface

// File: rtl/pixel_reset_seq.sv
// Qualifies the pixel PLL lock in the clk_25m domain and releases the downstream
// resets one stage at a time; any loss of lock slams every stage back into reset.
module pixel_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP          = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clk_25m,
    input  logic             reset,
    pixel_reset_seq_if.slave bus
);
    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] LOST      = 3'd4;

    // One counter serves both the qualification window and the stage gaps.
    localparam int CMAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int CB   = $clog2(CMAX);
    localparam logic [CB-1:0] LOCK_LAST = CB'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CB-1:0] GAP_LAST  = CB'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [CB-1:0]          r_cnt;
    logic [NUM_STAGES-1:0]  r_rst_stage;
    logic                   r_ready;
    logic                   r_loss_pulse;
    logic [CNT_W-1:0]       r_loss_count;

    logic                   w_locked_s;
    logic [2:0]             w_state_nxt;
    logic [CB-1:0]          w_cnt_nxt;
    logic [NUM_STAGES-1:0]  w_rst_nxt;
    logic [NUM_STAGES-1:0]  w_rst_shift;
    logic                   w_ready_nxt;
    logic                   w_pulse_nxt;
    logic                   w_loss_ev;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_lock_done;
    logic                   w_gap_done;
    logic                   w_last_stage;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_locked_s   = r_sync[SYNC_STAGES-1];
    // Shifting a zero in at the LSB releases stages in order 0,1,2...
    assign w_rst_shift  = r_rst_stage << 1;
    assign w_last_stage = (w_rst_shift == '0);
    assign w_lock_done  = (r_cnt == LOCK_LAST);
    assign w_gap_done   = (r_cnt == GAP_LAST);

    always_ff @(posedge clk_25m or posedge reset) begin
        if (reset) begin
            r_sync       <= '0;
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_rst_stage  <= '1;
            r_ready      <= 1'b0;
            r_loss_pulse <= 1'b0;
            r_loss_count <= '0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.locked};
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rst_stage  <= w_rst_nxt;
            r_ready      <= w_ready_nxt;
            r_loss_pulse <= w_pulse_nxt;
            r_loss_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = WAIT_LOCK;
        case (r_state)
            WAIT_LOCK: w_state_nxt = w_locked_s ? STABLE : WAIT_LOCK;
            STABLE: begin
                if (!w_locked_s)
                    w_state_nxt = WAIT_LOCK;
                else if (w_lock_done)
                    w_state_nxt = w_last_stage ? RUN : RELEASE;
                else
                    w_state_nxt = STABLE;
            end
            RELEASE: begin
                if (!w_locked_s)
                    w_state_nxt = LOST;
                else if (w_gap_done && w_last_stage)
                    w_state_nxt = RUN;
                else
                    w_state_nxt = RELEASE;
            end
            RUN:     w_state_nxt = w_locked_s ? RUN : LOST;
            LOST:    w_state_nxt = WAIT_LOCK;
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        w_pulse_nxt = 1'b0;
        w_loss_ev   = 1'b0;
        case (r_state)
            STABLE: begin
                if (w_locked_s) begin
                    if (w_lock_done) begin
                        w_rst_nxt   = w_rst_shift;
                        w_ready_nxt = w_last_stage;
                    end else begin
                        w_cnt_nxt = r_cnt + CB'(1);
                    end
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_loss_ev   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end else if (w_gap_done) begin
                    w_rst_nxt   = w_rst_shift;
                    w_ready_nxt = w_last_stage;
                end else begin
                    w_rst_nxt = r_rst_stage;
                    w_cnt_nxt = r_cnt + CB'(1);
                end
            end
            RUN: begin
                if (w_locked_s) begin
                    w_rst_nxt   = '0;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_loss_ev   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end
            end
            default: ;
        endcase

        // A clear that lands on a loss still records that loss.
        if (w_loss_ev)
            w_count_nxt = bus.clr_count ? CNT_W'(1) : sat_inc(r_loss_count);
        else
            w_count_nxt = bus.clr_count ? '0 : r_loss_count;
    end

    assign bus.rst_stage  = r_rst_stage;
    assign bus.ready      = r_ready;
    assign bus.loss_pulse = r_loss_pulse;
    assign bus.loss_count = r_loss_count;
    assign bus.state      = r_state;
endmodule
